// File: rtl/mio_arbiter.sv
// Two-master to one-slave memory arbiter with round-robin selection and a BUSY watchdog.
// state | meaning
// IDLE  | waiting for a request, grant = 00
// BUSY  | slave request outstanding, counting cycles toward TIMEOUT
// DONE  | one-cycle ready pulse to the owner, pointer update
module mio_arbiter #(
   parameter logic [7:0] TIMEOUT = 8'd255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        m0_req,
   input  logic        m0_we,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   output logic [31:0] m0_rdata,
   output logic        m0_ready,
   input  logic        m1_req,
   input  logic        m1_we,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   output logic [31:0] m1_rdata,
   output logic        m1_ready,
   output logic        s_req,
   output logic        s_we,
   output logic [31:0] s_addr,
   output logic [31:0] s_wdata,
   input  logic [31:0] s_rdata,
   input  logic        s_ack,
   output logic [1:0]  grant,
   output logic        timeout_err
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t      state_q;
   logic        owner_q;
   logic        last_q;
   logic [7:0]  cnt_q;
   logic        s_req_q, s_we_q;
   logic [31:0] s_addr_q, s_wdata_q;
   logic [31:0] m0_rdata_q, m1_rdata_q;
   logic        m0_ready_q, m1_ready_q;
   logic [1:0]  grant_q;
   logic        timeout_err_q;

   logic        sel_m1_d;
   logic        tmo_hit_d;

   // last_q = 1 means m1 was served last, so m0 wins a tie
   assign sel_m1_d  = m1_req & (~m0_req | ~last_q);
   assign tmo_hit_d = (TIMEOUT != 8'd0) && (cnt_q == (TIMEOUT - 8'd1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= IDLE;
         owner_q       <= 1'b0;
         last_q        <= 1'b1;
         cnt_q         <= 8'd0;
         s_req_q       <= 1'b0;
         s_we_q        <= 1'b0;
         s_addr_q      <= 32'd0;
         s_wdata_q     <= 32'd0;
         m0_rdata_q    <= 32'd0;
         m1_rdata_q    <= 32'd0;
         m0_ready_q    <= 1'b0;
         m1_ready_q    <= 1'b0;
         grant_q       <= 2'b00;
         timeout_err_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (m0_req || m1_req) begin
                  owner_q   <= sel_m1_d;
                  s_we_q    <= sel_m1_d ? m1_we    : m0_we;
                  s_addr_q  <= sel_m1_d ? m1_addr  : m0_addr;
                  s_wdata_q <= sel_m1_d ? m1_wdata : m0_wdata;
                  grant_q   <= sel_m1_d ? 2'b10 : 2'b01;
                  s_req_q   <= 1'b1;
                  cnt_q     <= 8'd0;
                  state_q   <= BUSY;
               end
            end
            BUSY: begin
               // ack wins over a timeout landing in the same cycle
               if (s_ack || tmo_hit_d) begin
                  if (!s_we_q) begin
                     if (owner_q) m1_rdata_q <= s_ack ? s_rdata : 32'hDEADBEEF;
                     else         m0_rdata_q <= s_ack ? s_rdata : 32'hDEADBEEF;
                  end
                  if (!s_ack) timeout_err_q <= 1'b1;
                  m0_ready_q <= ~owner_q;
                  m1_ready_q <= owner_q;
                  s_req_q    <= 1'b0;
                  state_q    <= DONE;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            DONE: begin
               m0_ready_q <= 1'b0;
               m1_ready_q <= 1'b0;
               grant_q    <= 2'b00;
               last_q     <= owner_q;
               state_q    <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign s_req       = s_req_q;
   assign s_we        = s_we_q;
   assign s_addr      = s_addr_q;
   assign s_wdata     = s_wdata_q;
   assign m0_rdata    = m0_rdata_q;
   assign m1_rdata    = m1_rdata_q;
   assign m0_ready    = m0_ready_q;
   assign m1_ready    = m1_ready_q;
   assign grant       = grant_q;
   assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_mio_arbiter.sv
// Directed bench for mio_arbiter with TIMEOUT = 4 and hand-computed expectations.
module tb_mio_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        m0_req, m0_we, m1_req, m1_we;
   logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
   logic [31:0] m0_rdata, m1_rdata;
   logic        m0_ready, m1_ready;
   logic        s_req, s_we, s_ack;
   logic [31:0] s_addr, s_wdata, s_rdata;
   logic [1:0]  grant;
   logic        timeout_err;

   int n_tests = 0;
   int n_fail  = 0;

   mio_arbiter #(.TIMEOUT(8'd4)) dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_rdata(m0_rdata), .m0_ready(m0_ready),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_rdata(m1_rdata), .m1_ready(m1_ready),
      .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
      .s_rdata(s_rdata), .s_ack(s_ack),
      .grant(grant), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      tick();
      tick();
      rst = 1'b1;
   endtask

   initial begin
      m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
      m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
      s_ack = 0; s_rdata = 0;
      rst = 1'b0;
      #3;
      chk("rst_s_req", {31'd0, s_req}, 32'd0);
      chk("rst_grant", {30'd0, grant}, 32'd0);
      chk("rst_m0_rdata", m0_rdata, 32'd0);
      chk("rst_m1_rdata", m1_rdata, 32'd0);
      chk("rst_tmo", {31'd0, timeout_err}, 32'd0);
      chk("rst_ready", {30'd0, m1_ready, m0_ready}, 32'd0);
      chk("rst_s_addr", s_addr, 32'd0);
      tick();
      rst = 1'b1;
      tick();

      // single read, m0, request dropped during BUSY, ack in 3rd BUSY cycle
      m0_req = 1; m0_we = 0; m0_addr = 32'h100;
      tick();
      chk("rd_s_req", {31'd0, s_req}, 32'd1);
      chk("rd_grant_busy", {30'd0, grant}, 32'd1);
      chk("rd_s_addr", s_addr, 32'h100);
      chk("rd_s_we", {31'd0, s_we}, 32'd0);
      m0_req = 0;
      tick();
      tick();
      s_ack = 1; s_rdata = 32'h12345678;
      tick();
      s_ack = 0;
      chk("rd_m0_ready", {31'd0, m0_ready}, 32'd1);
      chk("rd_m1_ready", {31'd0, m1_ready}, 32'd0);
      chk("rd_m0_rdata", m0_rdata, 32'h12345678);
      chk("rd_grant_done", {30'd0, grant}, 32'd1);
      chk("rd_s_req_done", {31'd0, s_req}, 32'd0);
      tick();
      chk("rd_ready_once", {31'd0, m0_ready}, 32'd0);
      chk("rd_grant_idle", {30'd0, grant}, 32'd0);

      // m1 write
      m1_req = 1; m1_we = 1; m1_addr = 32'h20; m1_wdata = 32'hA5A5A5A5;
      tick();
      m1_req = 0; m1_addr = 32'h0; m1_wdata = 32'h0;
      chk("wr_grant", {30'd0, grant}, 32'd2);
      chk("wr_s_we", {31'd0, s_we}, 32'd1);
      chk("wr_s_addr", s_addr, 32'h20);
      tick();
      chk("wr_s_addr_stable", s_addr, 32'h20);
      chk("wr_s_wdata_stable", s_wdata, 32'hA5A5A5A5);
      s_ack = 1; s_rdata = 32'hFFFF0000;
      tick();
      s_ack = 0;
      chk("wr_m1_ready", {31'd0, m1_ready}, 32'd1);
      chk("wr_m0_ready", {31'd0, m0_ready}, 32'd0);
      chk("wr_m1_rdata", m1_rdata, 32'd0);
      tick();

      // contention after reset: m0, m1, m0, m1
      do_reset();
      m0_req = 1; m0_we = 0; m0_addr = 32'h0;
      m1_req = 1; m1_we = 0; m1_addr = 32'h4;
      for (int i = 0; i < 4; i++) begin
         logic [31:0] gexp;
         gexp = (i % 2 == 0) ? 32'd1 : 32'd2;
         tick();
         chk($sformatf("ct_grant%0d", i), {30'd0, grant}, gexp);
         chk($sformatf("ct_s_addr%0d", i), s_addr, (i % 2 == 0) ? 32'h0 : 32'h4);
         s_ack = 1; s_rdata = 32'hC0000000 + i;
         tick();
         s_ack = 0;
         chk($sformatf("ct_ready%0d", i), {30'd0, m1_ready, m0_ready}, gexp);
         chk($sformatf("ct_rdata%0d", i), (i % 2 == 0) ? m0_rdata : m1_rdata,
             32'hC0000000 + i);
         tick();
         chk($sformatf("ct_idle%0d", i), {30'd0, grant}, 32'd0);
         if (i == 3) begin
            m0_req = 0; m1_req = 0;
         end
      end

      // stray ack in IDLE is ignored
      s_ack = 1; s_rdata = 32'h55555555;
      tick();
      s_ack = 0;
      chk("stray_s_req", {31'd0, s_req}, 32'd0);
      chk("stray_grant", {30'd0, grant}, 32'd0);
      chk("stray_ready", {30'd0, m1_ready, m0_ready}, 32'd0);
      chk("stray_m0_rdata", m0_rdata, 32'hC0000002);

      // timeout, no ack for 4 BUSY cycles
      m0_req = 1; m0_we = 0; m0_addr = 32'h40;
      tick();
      m0_req = 0;
      tick();
      tick();
      tick();
      chk("to_busy4_s_req", {31'd0, s_req}, 32'd1);
      chk("to_busy4_err", {31'd0, timeout_err}, 32'd0);
      tick();
      chk("to_s_req", {31'd0, s_req}, 32'd0);
      chk("to_m0_ready", {31'd0, m0_ready}, 32'd1);
      chk("to_m0_rdata", m0_rdata, 32'hDEADBEEF);
      chk("to_err", {31'd0, timeout_err}, 32'd1);
      tick();
      tick();
      chk("to_err_sticky", {31'd0, timeout_err}, 32'd1);

      // ack on the limit cycle wins
      do_reset();
      chk("al_err_cleared", {31'd0, timeout_err}, 32'd0);
      m1_req = 1; m1_we = 0; m1_addr = 32'h80;
      tick();
      m1_req = 0;
      tick();
      tick();
      tick();
      s_ack = 1; s_rdata = 32'h0BADF00D;
      tick();
      s_ack = 0;
      chk("al_m1_ready", {31'd0, m1_ready}, 32'd1);
      chk("al_m1_rdata", m1_rdata, 32'h0BADF00D);
      chk("al_err", {31'd0, timeout_err}, 32'd0);
      tick();

      // reset mid-BUSY, then a late ack
      m0_req = 1; m0_we = 0; m0_addr = 32'h200;
      tick();
      m0_req = 0;
      chk("rb_s_req", {31'd0, s_req}, 32'd1);
      #2 rst = 1'b0;
      #1;
      chk("rb_async_s_req", {31'd0, s_req}, 32'd0);
      chk("rb_async_grant", {30'd0, grant}, 32'd0);
      chk("rb_async_s_addr", s_addr, 32'd0);
      tick();
      rst = 1'b1;
      s_ack = 1; s_rdata = 32'h77777777;
      tick();
      s_ack = 0;
      chk("rb_ready", {30'd0, m1_ready, m0_ready}, 32'd0);
      chk("rb_s_req_after", {31'd0, s_req}, 32'd0);
      chk("rb_grant_after", {30'd0, grant}, 32'd0);
      chk("rb_m0_rdata", m0_rdata, 32'd0);
      tick();
      chk("rb_ready2", {30'd0, m1_ready, m0_ready}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
